// File: rtl/salsa20_inv_core.sv
// salsa20_inv_core: iterative inverse of the Salsa20 double-round.
// Undoes ROUNDS forward rounds (no feed-forward add), one inverse round per clock.
// Forward order is column round then row round, so the inverse starts with a row round.
module salsa20_inv_core #(
  parameter int ROUNDS = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_state,
  output logic         busy
);

  localparam int CW = $clog2(ROUNDS + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             st;
  logic [CW-1:0]      cnt;
  logic [15:0][31:0]  w;
  logic [15:0][31:0]  w_next;

  function automatic logic [31:0] rotl(input logic [31:0] v, input int unsigned n);
    return (v << n) | (v >> (32 - n));
  endfunction

  // Undo the forward quarter-round steps in reverse order; each step uses
  // words already restored by the previous one.
  function automatic logic [127:0] inv_qr(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] c, input logic [31:0] d);
    logic [31:0] a2, b2, c2, d2;
    a2 = a ^ rotl(d + c, 18);
    d2 = d ^ rotl(c + b, 13);
    c2 = c ^ rotl(b + a2, 9);
    b2 = b ^ rotl(a2 + d2, 7);
    return {a2, b2, c2, d2};
  endfunction

  // One inverse round: row round on even counter values, column round on odd.
  always_comb begin
    w_next = w;
    if (!cnt[0]) begin
      {w_next[0],  w_next[1],  w_next[2],  w_next[3]}  = inv_qr(w[0],  w[1],  w[2],  w[3]);
      {w_next[5],  w_next[6],  w_next[7],  w_next[4]}  = inv_qr(w[5],  w[6],  w[7],  w[4]);
      {w_next[10], w_next[11], w_next[8],  w_next[9]}  = inv_qr(w[10], w[11], w[8],  w[9]);
      {w_next[15], w_next[12], w_next[13], w_next[14]} = inv_qr(w[15], w[12], w[13], w[14]);
    end else begin
      {w_next[0],  w_next[4],  w_next[8],  w_next[12]} = inv_qr(w[0],  w[4],  w[8],  w[12]);
      {w_next[5],  w_next[9],  w_next[13], w_next[1]}  = inv_qr(w[5],  w[9],  w[13], w[1]);
      {w_next[10], w_next[14], w_next[2],  w_next[6]}  = inv_qr(w[10], w[14], w[2],  w[6]);
      {w_next[15], w_next[3],  w_next[7],  w_next[11]} = inv_qr(w[15], w[3],  w[7],  w[11]);
    end
  end

  // Control FSM with registered handshake outputs and the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      st        <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      cnt       <= '0;
      w         <= '0;
    end else begin
      case (st)
        IDLE: begin
          if (in_valid) begin
            w        <= in_state;
            cnt      <= '0;
            st       <= RUN;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        RUN: begin
          w   <= w_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ROUNDS - 1)) begin
            st        <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            st        <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign out_state = w;

endmodule

// File: tb/tb_salsa20_inv_core.sv
// Testbench for salsa20_inv_core: a forward Salsa20 round model generates
// round inputs and checks that the DUT recovers the original state.
module tb_salsa20_inv_core;

  typedef logic [15:0][31:0] st_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         iv20, ir20, ov20, or20, b20;
  logic [511:0] is20, os20;
  logic         iv2, ir2, ov2, or2, b2;
  logic [511:0] is2, os2;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  salsa20_inv_core #(.ROUNDS(20)) dut20 (
    .clk(clk), .rst(rst), .in_valid(iv20), .in_ready(ir20), .in_state(is20),
    .out_valid(ov20), .out_ready(or20), .out_state(os20), .busy(b20)
  );

  salsa20_inv_core #(.ROUNDS(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .in_state(is2),
    .out_valid(ov2), .out_ready(or2), .out_state(os2), .busy(b2)
  );

  // ---------------- reference model (forward Salsa20 rounds) ----------------
  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic st_t fqr(input st_t x, input int a, input int b, input int c, input int d);
    x[b] = x[b] ^ rotl(x[a] + x[d], 7);
    x[c] = x[c] ^ rotl(x[b] + x[a], 9);
    x[d] = x[d] ^ rotl(x[c] + x[b], 13);
    x[a] = x[a] ^ rotl(x[d] + x[c], 18);
    return x;
  endfunction

  function automatic st_t fwd(input st_t s, input int rounds);
    int col[16] = '{0, 4, 8, 12, 5, 9, 13, 1, 10, 14, 2, 6, 15, 3, 7, 11};
    int row[16] = '{0, 1, 2, 3, 5, 6, 7, 4, 10, 11, 8, 9, 15, 12, 13, 14};
    for (int r = 0; r < rounds; r++) begin
      for (int g = 0; g < 4; g++) begin
        if (r % 2 == 0) s = fqr(s, col[4*g], col[4*g+1], col[4*g+2], col[4*g+3]);
        else            s = fqr(s, row[4*g], row[4*g+1], row[4*g+2], row[4*g+3]);
      end
    end
    return s;
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int i = 0; i < 16; i++) s[i] = $urandom;
    return s;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept20(input logic [511:0] s);
    iv20 = 1'b1;
    is20 = s;
    tick();
    iv20 = 1'b0;
  endtask

  task automatic accept2(input logic [511:0] s);
    iv2 = 1'b1;
    is2 = s;
    tick();
    iv2 = 1'b0;
  endtask

  task automatic wait20(output int lat);
    lat = 0;
    while (!ov20 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic wait2(output int lat);
    lat = 0;
    while (!ov2 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic release20();
    or20 = 1'b1;
    tick();
    or20 = 1'b0;
  endtask

  task automatic release2();
    or2 = 1'b1;
    tick();
    or2 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (ir20 !== 1'b1) begin bad++; $display("FAIL reset_in_ready20: got %b expected 1", ir20); end
    total++; if (ov20 !== 1'b0) begin bad++; $display("FAIL reset_out_valid20: got %b expected 0", ov20); end
    total++; if (b20 !== 1'b0) begin bad++; $display("FAIL reset_busy20: got %b expected 0", b20); end
    total++; if (os20 !== '0) begin bad++; $display("FAIL reset_out_state20: got %h expected 0", os20); end
    total++; if (ir2 !== 1'b1) begin bad++; $display("FAIL reset_in_ready2: got %b expected 1", ir2); end
    total++; if (os2 !== '0) begin bad++; $display("FAIL reset_out_state2: got %h expected 0", os2); end
  endtask

  task automatic test_zero();
    int lat;
    accept20('0);
    total++; if (b20 !== 1'b1 || ir20 !== 1'b0) begin bad++; $display("FAIL zero_run_flags: got busy=%b in_ready=%b expected busy=1 in_ready=0", b20, ir20); end
    wait20(lat);
    total++; if (lat != 20) begin bad++; $display("FAIL zero_latency: got %0d expected 20", lat); end
    total++; if (os20 !== '0) begin bad++; $display("FAIL zero_out_state: got %h expected 0", os20); end
    release20();
    total++; if (ov20 !== 1'b0 || ir20 !== 1'b1) begin bad++; $display("FAIL zero_release: got out_valid=%b in_ready=%b expected 0 1", ov20, ir20); end
  endtask

  task automatic test_known_r2();
    st_t s;
    int lat;
    for (int i = 0; i < 16; i++) s[i] = (i % 4 == 0) ? 32'h1 : 32'h0;
    accept2(fwd(s, 2));
    wait2(lat);
    total++; if (lat != 2) begin bad++; $display("FAIL r2_latency: got %0d expected 2", lat); end
    total++; if (os2 !== s) begin bad++; $display("FAIL r2_out_state: got %h expected %h", os2, s); end
    release2();
  endtask

  task automatic test_qr_vector();
    st_t x;
    int lat;
    x = '0;
    x[0] = 32'h08008145;
    x[1] = 32'h00000080;
    x[2] = 32'h00010200;
    x[3] = 32'h20500000;
    accept2(x);
    wait2(lat);
    total++; if (lat != 2) begin bad++; $display("FAIL qr_latency: got %0d expected 2", lat); end
    total++; if (fwd(os2, 2) !== x) begin bad++; $display("FAIL qr_roundtrip: got %h expected %h", fwd(os2, 2), x); end
    release2();
  endtask

  task automatic test_random_hold();
    st_t s;
    int lat;
    s = rand_state();
    accept20(fwd(s, 20));
    wait20(lat);
    total++; if (lat != 20) begin bad++; $display("FAIL hold_latency: got %0d expected 20", lat); end
    total++; if (os20 !== s) begin bad++; $display("FAIL hold_out_state: got %h expected %h", os20, s); end
    for (int k = 0; k < 5; k++) begin
      tick();
      total++;
      if (os20 !== s || ir20 !== 1'b0 || ov20 !== 1'b1) begin
        bad++;
        $display("FAIL hold_stable_%0d: got in_ready=%b out_valid=%b state_ok=%b expected 0 1 1", k, ir20, ov20, os20 === s);
      end
    end
    release20();
  endtask

  task automatic test_reset_mid_run();
    st_t s;
    int lat;
    accept20(fwd(rand_state(), 20));
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++; if (ir20 !== 1'b1) begin bad++; $display("FAIL midrst_in_ready: got %b expected 1", ir20); end
    total++; if (ov20 !== 1'b0) begin bad++; $display("FAIL midrst_out_valid: got %b expected 0", ov20); end
    total++; if (b20 !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b expected 0", b20); end
    total++; if (os20 !== '0) begin bad++; $display("FAIL midrst_out_state: got %h expected 0", os20); end
    s = rand_state();
    accept20(fwd(s, 20));
    wait20(lat);
    total++; if (lat != 20) begin bad++; $display("FAIL midrst_new_latency: got %0d expected 20", lat); end
    total++; if (os20 !== s) begin bad++; $display("FAIL midrst_new_state: got %h expected %h", os20, s); end
    release20();
  endtask

  task automatic test_back_to_back();
    st_t s[3];
    int lat, low;
    for (int j = 0; j < 3; j++) s[j] = rand_state();
    or20 = 1'b1;
    iv20 = 1'b1;
    is20 = fwd(s[0], 20);
    for (int j = 0; j < 3; j++) begin
      tick();                       // accept edge
      is20 = rand_state();          // junk while in_valid stays high in RUN
      lat = 0;
      low = 0;
      while (!ov20 && lat < 100) begin
        if (!ir20) low++;
        tick();
        lat++;
      end
      if (!ir20) low++;
      total++; if (lat != 20) begin bad++; $display("FAIL b2b_latency_%0d: got %0d expected 20", j, lat); end
      total++; if (os20 !== s[j]) begin bad++; $display("FAIL b2b_state_%0d: got %h expected %h", j, os20, s[j]); end
      if (j < 2) is20 = fwd(s[j+1], 20);
      else       iv20 = 1'b0;
      tick();
      total++; if (ir20 !== 1'b1 || ov20 !== 1'b0) begin bad++; $display("FAIL b2b_idle_%0d: got in_ready=%b out_valid=%b expected 1 0", j, ir20, ov20); end
      total++; if (low != 21) begin bad++; $display("FAIL b2b_ready_low_%0d: got %0d expected 21", j, low); end
    end
    or20 = 1'b0;
    iv20 = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    iv20 = 1'b0; or20 = 1'b0; is20 = '0;
    iv2  = 1'b0; or2  = 1'b0; is2  = '0;
    test_reset();
    test_zero();
    test_known_r2();
    test_qr_vector();
    test_random_hold();
    test_reset_mid_run();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
